// File: rtl/data_mem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the memory-stage load/store port.
// Revision : 1.0
// ============================================================================
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  localparam logic [3:0] c_BE_BYTE = 4'b0001;
  localparam logic [3:0] c_BE_HALF = 4'b0011;
  localparam logic [3:0] c_BE_WORD = 4'b1111;

  // Stores have no unsigned variants, so any funct3 with bit 2 set is illegal there.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    return (f3 == 3'b011) || (f3[2] && (is_store || f3[1]));
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_port_if
// Purpose  : Request/acknowledge data-memory bus between the port and memory.
// Revision : 1.0
// ============================================================================
interface data_mem_port_if #(
  parameter int ADDR_W = 32
) ();

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface
`default_nettype wire

// File: rtl/data_mem_port_lane_fmt.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_fmt
// Purpose  : Store lane replication / byte enables and load extraction / extension.
// Revision : 1.0
// ============================================================================
module mem_lane_fmt
  import mem_pkg::*;
(
  input  wire logic [2:0]  i_st_funct3,
  input  wire logic [1:0]  i_st_addr_lo,
  input  wire logic [31:0] i_st_wdata,
  output logic [3:0]       o_st_be,
  output logic [31:0]      o_st_data,
  input  wire logic [2:0]  i_ld_funct3,
  input  wire logic [1:0]  i_ld_addr_lo,
  input  wire logic [31:0] i_ld_rdata,
  output logic [31:0]      o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_be   = c_BE_WORD;
    o_st_data = i_st_wdata;
    case (i_st_funct3[1:0])
      2'b00: begin
        o_st_be   = c_BE_BYTE << i_st_addr_lo;
        o_st_data = {4{i_st_wdata[7:0]}};
      end
      2'b01: begin
        o_st_be   = c_BE_HALF << i_st_addr_lo;
        o_st_data = {2{i_st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_rdata[7:0];
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      default: w_byte = i_ld_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_funct3)
      c_F3_LB:  o_ld_data = {{24{w_byte[7]}}, w_byte};
      c_F3_LH:  o_ld_data = {{16{w_half[15]}}, w_half};
      c_F3_LW:  o_ld_data = i_ld_rdata;
      c_F3_LBU: o_ld_data = {24'd0, w_byte};
      c_F3_LHU: o_ld_data = {16'd0, w_half};
      default:  o_ld_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_port
// Purpose  : MEM-stage load/store sequencer driving a req/ack data-memory bus.
// Revision : 1.0
// ============================================================================
module data_mem_port
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              MemRead,
  input  wire logic              MemWrite,
  input  wire logic [2:0]        Funct3,
  input  wire logic [ADDR_W-1:0] Addr,
  input  wire logic [31:0]       WrData,
  output logic [31:0]            RdData,
  output logic                   Stall,
  output logic                   Misaligned,
  output logic                   BusErr,
  data_mem_port_if.master        bus
);

  localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t            r_state;
  logic [7:0]        r_wait;
  logic              r_err;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic [31:0]       r_rdata;
  logic              r_req;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_any;
  logic              w_illegal;
  logic              w_misaligned;
  logic              w_start;
  logic [3:0]        w_st_be;
  logic [31:0]       w_st_data;
  logic [31:0]       w_ld_data;

  mem_lane_fmt u_lane_fmt (
    .i_st_funct3  (Funct3),
    .i_st_addr_lo (Addr[1:0]),
    .i_st_wdata   (WrData),
    .o_st_be      (w_st_be),
    .o_st_data    (w_st_data),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_rdata   (bus.mem_rdata),
    .o_ld_data    (w_ld_data)
  );

  // Request decode is combinational so refusals cost no cycle and a legal access stalls at once.
  always_comb begin
    w_any        = (MemRead | MemWrite) & (r_state == ST_IDLE) & ~reset;
    w_illegal    = f3_illegal(Funct3, MemWrite);
    w_misaligned = ((Funct3[1:0] == 2'b01) & Addr[0]) |
                   ((Funct3[1:0] == 2'b10) & (Addr[1:0] != 2'b00));
    w_start      = w_any & ~w_illegal & ~w_misaligned;
  end

  assign Stall      = w_start | (r_state == ST_BUSY);
  assign Misaligned = w_any & ~w_illegal & w_misaligned;
  assign BusErr     = (w_any & w_illegal) | ((r_state == ST_DONE) & r_err);
  assign RdData     = r_rdata;

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_be    = r_be;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_wait    <= '0;
      r_err     <= 1'b0;
      r_funct3  <= '0;
      r_addr_lo <= '0;
      r_rdata   <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_BUSY;
            r_req     <= 1'b1;
            r_we      <= MemWrite;
            r_be      <= w_st_be;
            r_addr    <= {Addr[ADDR_W-1:2], 2'b00};
            r_wdata   <= MemWrite ? w_st_data : 32'd0;
            r_funct3  <= Funct3;
            r_addr_lo <= Addr[1:0];
            r_wait    <= '0;
            r_err     <= 1'b0;
          end
        end
        ST_BUSY: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (bus.mem_ack) begin
            r_rdata <= w_ld_data;
            r_req   <= 1'b0;
            r_state <= ST_DONE;
          end else if (r_wait == c_WAIT_LAST) begin
            r_rdata <= '0;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        ST_DONE: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_port
// Purpose  : Directed scoreboard bench for the memory-stage load/store port.
// Revision : 1.0
// ============================================================================
module tb_data_mem_port;
  import mem_pkg::*;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Stall;
  logic        Misaligned;
  logic        BusErr;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_rd = 32'd0;

  data_mem_port_if #(.ADDR_W(32)) bus ();

  data_mem_port #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .Addr       (Addr),
    .WrData     (WrData),
    .RdData     (RdData),
    .Stall      (Stall),
    .Misaligned (Misaligned),
    .BusErr     (BusErr),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rd;
    logic        chk_rd;
    logic        err;
    int          stall;
    int          req;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t res_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int ack_after,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_busy);
    bus_exp_t bx;
    res_exp_t rx;
    int       n_stall;
    int       n_req;
    bit       done;
    @(posedge clk); #1;
    MemWrite      = we;
    MemRead       = ~we;
    Funct3        = f3;
    Addr          = addr;
    WrData        = wdata;
    bus.mem_rdata = rdata;
    bus_q.push_back('{we: we, be: exp_be, addr: addr & 32'hFFFF_FFFC, wdata: exp_wdata});
    res_q.push_back('{rd: exp_rd, chk_rd: ~we, err: exp_err, stall: exp_busy + 1, req: exp_busy});
    if (!we) last_rd = exp_rd;
    @(negedge clk);
    check({tag, ".idle_stall"}, Stall, 1'b1);
    check({tag, ".idle_req"}, bus.mem_req, 1'b0);
    n_stall = 1;
    n_req   = 0;
    done    = 1'b0;
    bx      = '{we: 1'b0, be: 4'd0, addr: 32'd0, wdata: 32'd0};
    for (int c = 1; c <= MAX_WAIT + 4 && !done; c++) begin
      @(posedge clk); #1;
      bus.mem_ack = (c == ack_after);
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        n_req++;
        if (n_req == 1) begin
          checks++;
          assert (bus_q.size() != 0) else begin
            errors++;
            $error("FAIL %s.bus_q: observed empty expected entry", tag);
          end
          if (bus_q.size() != 0) bx = bus_q.pop_front();
        end
        check({tag, ".we"}, bus.mem_we, bx.we);
        check({tag, ".addr"}, bus.mem_addr, bx.addr);
        if (bx.we) begin
          check({tag, ".be"}, bus.mem_be, bx.be);
          check({tag, ".wdata"}, bus.mem_wdata, bx.wdata);
        end
      end
      if (Stall === 1'b1) begin
        n_stall++;
      end else begin
        done = 1'b1;
        rx = res_q.pop_front();
        check({tag, ".stall_cycles"}, n_stall, rx.stall);
        check({tag, ".req_cycles"}, n_req, rx.req);
        check({tag, ".buserr"}, BusErr, rx.err);
        if (rx.chk_rd) check({tag, ".rddata"}, RdData, rx.rd);
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        bus.mem_ack = 1'b0;
      end
    end
    check({tag, ".done_reached"}, done, 1'b1);
    if (!done) begin
      res_q.delete();
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      bus.mem_ack = 1'b0;
    end
    bus_q.delete();
  endtask

  task automatic refuse(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic exp_mis, input logic exp_err);
    @(posedge clk); #1;
    MemWrite    = we;
    MemRead     = 1'b1;
    Funct3      = f3;
    Addr        = addr;
    WrData      = 32'h1357_9BDF;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check({tag, ".misaligned"}, Misaligned, exp_mis);
    check({tag, ".buserr"}, BusErr, exp_err);
    check({tag, ".stall"}, Stall, 1'b0);
    check({tag, ".req"}, bus.mem_req, 1'b0);
    @(posedge clk); #1;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check({tag, ".req_after"}, bus.mem_req, 1'b0);
    check({tag, ".pulse_end"}, {30'd0, Misaligned, BusErr}, 32'd0);
    check({tag, ".rd_hold"}, RdData, last_rd);
  endtask

  initial begin
    reset         = 1'b1;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    Funct3        = 3'd0;
    Addr          = 32'd0;
    WrData        = 32'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.rddata", RdData, 32'd0);
    check("rst.flags", {29'd0, Stall, Misaligned, BusErr}, 32'd0);
    check("rst.req_we_be", {27'd0, bus.mem_req, bus.mem_we, bus.mem_be}, 32'd0);
    check("rst.addr", bus.mem_addr, 32'd0);
    check("rst.wdata", bus.mem_wdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    access("sw",  1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'd0, 1, 4'b1111, 32'hDEAD_BEEF, 32'd0, 1'b0, 1);
    access("sb",  1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'd0, 1, 4'b1000, 32'hA5A5_A5A5, 32'd0, 1'b0, 1);
    access("sh",  1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'd0, 2, 4'b1100, 32'h1234_1234, 32'd0, 1'b0, 2);
    access("lb",  1'b0, c_F3_LB,  32'h102, 32'd0, 32'h0080_FF00, 3, 4'd0, 32'd0, 32'hFFFF_FF80, 1'b0, 3);
    access("lbu", 1'b0, c_F3_LBU, 32'h102, 32'd0, 32'h0080_FF00, 1, 4'd0, 32'd0, 32'h0000_0080, 1'b0, 1);
    access("lh",  1'b0, c_F3_LH,  32'h102, 32'd0, 32'h8001_0000, 1, 4'd0, 32'd0, 32'hFFFF_8001, 1'b0, 1);
    access("lhu", 1'b0, c_F3_LHU, 32'h102, 32'd0, 32'h8001_0000, 2, 4'd0, 32'd0, 32'h0000_8001, 1'b0, 2);
    access("lw",  1'b0, c_F3_LW,  32'h104, 32'd0, 32'hCAFE_F00D, 1, 4'd0, 32'd0, 32'hCAFE_F00D, 1'b0, 1);

    refuse("lw_mis",   1'b0, c_F3_LW, 32'h102, 1'b1, 1'b0);
    refuse("lh_mis",   1'b0, c_F3_LH, 32'h101, 1'b1, 1'b0);
    refuse("f3_011",   1'b0, 3'b011,  32'h100, 1'b0, 1'b1);
    refuse("st_f3_100", 1'b1, 3'b100, 32'h100, 1'b0, 1'b1);

    access("lw_tmo",  1'b0, c_F3_LW, 32'h108, 32'd0, 32'h1111_2222, 0,        4'd0, 32'd0, 32'd0,        1'b1, MAX_WAIT);
    access("lw_last", 1'b0, c_F3_LW, 32'h10C, 32'd0, 32'h3333_4444, MAX_WAIT, 4'd0, 32'd0, 32'h3333_4444, 1'b0, MAX_WAIT);

    // Reset lands at the end of the second BUSY cycle; the ack after it must be ignored.
    @(posedge clk); #1;
    MemRead       = 1'b1;
    Funct3        = c_F3_LW;
    Addr          = 32'h200;
    bus.mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset   = 1'b1;
    MemRead = 1'b0;
    @(negedge clk);
    check("rstbusy.req_before", bus.mem_req, 1'b1);
    @(posedge clk); #1;
    reset       = 1'b0;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check("rstbusy.req", bus.mem_req, 1'b0);
    check("rstbusy.stall", Stall, 1'b0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("rstbusy.rddata", RdData, 32'd0);
    check("rstbusy.req_after", bus.mem_req, 1'b0);
    check("rstbusy.flags", {30'd0, Stall, BusErr}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
